// File: rtl/pdua_pkg.sv
// Shared definitions for the PDUA hardwired control unit: FSM states,
// opcode map, ALU operation codes, register-bank addresses and the
// control-word structure driven to the datapath every clock.
package pdua_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FA,
    S_FM,
    S_FI,
    S_EX1,
    S_EX2,
    S_EX3,
    S_HALT
  } state_e;

  // Opcodes (5-bit IR field)
  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_MOV_ACC_A = 5'b00001;
  localparam logic [4:0] OP_MOV_A_ACC = 5'b00010;
  localparam logic [4:0] OP_LD        = 5'b00011;  // MOV ACC,[DPTR]
  localparam logic [4:0] OP_ST        = 5'b00100;  // MOV [DPTR],ACC
  localparam logic [4:0] OP_ADD       = 5'b00101;
  localparam logic [4:0] OP_AND       = 5'b00110;
  localparam logic [4:0] OP_NOT       = 5'b00111;
  localparam logic [4:0] OP_SHL       = 5'b01000;
  localparam logic [4:0] OP_SHR       = 5'b01001;
  localparam logic [4:0] OP_JMP       = 5'b01010;
  localparam logic [4:0] OP_JZ        = 5'b01011;
  localparam logic [4:0] OP_JN        = 5'b01100;
  localparam logic [4:0] OP_JC        = 5'b01101;
  localparam logic [4:0] OP_JP        = 5'b01110;
  localparam logic [4:0] OP_HALT      = 5'b11111;

  // ALU operations; operand A is always ACC, operand B is BusB
  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_NOT   = 3'b011;
  localparam logic [2:0] ALU_INC   = 3'b100;
  localparam logic [2:0] ALU_SHL   = 3'b101;
  localparam logic [2:0] ALU_SHR   = 3'b110;

  // Register-bank map
  localparam logic [2:0] R_PC   = 3'd0;
  localparam logic [2:0] R_SP   = 3'd1;
  localparam logic [2:0] R_DPTR = 3'd2;
  localparam logic [2:0] R_A    = 3'd3;
  localparam logic [2:0] R_AVI  = 3'd4;
  localparam logic [2:0] R_TEMP = 3'd5;
  localparam logic [2:0] R_ONE  = 3'd6;
  localparam logic [2:0] R_ACC  = 3'd7;

  typedef struct packed {
    logic       wr_rdn;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busb_addr;
    logic [2:0] busc_addr;
    logic       busb_mdr_sel;
    logic       sclr;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       mdr_alu_n;
    logic       halted;
  } ctrl_t;

  function automatic logic is_jump(input logic [4:0] op);
    return (op >= OP_JMP) && (op <= OP_JP);
  endfunction

  // Branch condition; JMP is unconditional
  function automatic logic jump_taken(input logic [4:0] op,
                                      input logic c, input logic n,
                                      input logic p, input logic z);
    logic t;
    t = 1'b0;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JZ:   t = z;
      OP_JN:   t = n;
      OP_JC:   t = c;
      OP_JP:   t = p;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic is_defined(input logic [4:0] op);
    return (op <= OP_JP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/pdua_ctrl_decode.sv
// Combinational decode of (state, opcode, flags, mem_ready) into the
// datapath control word. Memory-wait states only drive the bus direction
// and MDR source; mdr_en pulses in the cycle the memory reports ready.
module pdua_ctrl_decode
  import pdua_pkg::*;
(
  input  state_e     state_i,
  input  logic [4:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       p_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);

  // Control word for the current state
  always_comb begin
    // NOTE: every field defaults to 0 first, so no path can infer a latch.
    ctrl_o = '0;
    unique case (state_i)
      S_INIT: ctrl_o.sclr = 1'b1;
      S_FA: begin
        ctrl_o.busb_addr = R_PC;
        ctrl_o.selop     = ALU_PASS;
        ctrl_o.mar_en    = 1'b1;
      end
      S_FM: begin
        ctrl_o.mdr_alu_n = 1'b1;
        ctrl_o.mdr_en    = mem_ready_i;
      end
      S_FI: begin
        ctrl_o.ir_en      = 1'b1;
        ctrl_o.busb_addr  = R_PC;
        ctrl_o.selop      = ALU_INC;
        ctrl_o.busc_addr  = R_PC;
        ctrl_o.bank_wr_en = 1'b1;
      end
      S_EX1: begin
        case (opcode_i)
          OP_MOV_ACC_A: begin
            ctrl_o.busb_addr  = R_A;
            ctrl_o.busc_addr  = R_ACC;
            ctrl_o.selop      = ALU_PASS;
            ctrl_o.bank_wr_en = 1'b1;
            ctrl_o.enaf       = 1'b1;
          end
          OP_MOV_A_ACC: begin
            ctrl_o.busb_addr  = R_ACC;
            ctrl_o.busc_addr  = R_A;
            ctrl_o.selop      = ALU_PASS;
            ctrl_o.bank_wr_en = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctrl_o.busb_addr = R_DPTR;
            ctrl_o.selop     = ALU_PASS;
            ctrl_o.mar_en    = 1'b1;
          end
          OP_ADD, OP_AND: begin
            ctrl_o.busb_addr  = R_A;
            ctrl_o.selop      = (opcode_i == OP_ADD) ? ALU_ADD : ALU_AND;
            ctrl_o.busc_addr  = R_ACC;
            ctrl_o.bank_wr_en = 1'b1;
            ctrl_o.enaf       = 1'b1;
          end
          OP_NOT, OP_SHL, OP_SHR: begin
            ctrl_o.busb_addr  = R_ACC;
            ctrl_o.busc_addr  = R_ACC;
            ctrl_o.bank_wr_en = 1'b1;
            ctrl_o.enaf       = 1'b1;
            if (opcode_i == OP_NOT) begin
              ctrl_o.selop = ALU_NOT;
            end else begin
              ctrl_o.selop = (opcode_i == OP_SHL) ? ALU_SHL : ALU_SHR;
              ctrl_o.shamt = 2'b01;
            end
          end
          OP_JMP, OP_JZ, OP_JN, OP_JC, OP_JP: begin
            ctrl_o.busb_addr = R_PC;
            if (jump_taken(opcode_i, c_i, n_i, p_i, z_i)) begin
              // Point MAR at the operand byte
              ctrl_o.selop  = ALU_PASS;
              ctrl_o.mar_en = 1'b1;
            end else begin
              // Skip the operand byte
              ctrl_o.selop      = ALU_INC;
              ctrl_o.busc_addr  = R_PC;
              ctrl_o.bank_wr_en = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX2: begin
        if (opcode_i == OP_ST) begin
          ctrl_o.busb_addr = R_ACC;
          ctrl_o.selop     = ALU_PASS;
          ctrl_o.mdr_en    = 1'b1;
        end else begin
          // Operand/data read, held until memory is ready
          ctrl_o.mdr_alu_n = 1'b1;
          ctrl_o.mdr_en    = mem_ready_i;
        end
      end
      S_EX3: begin
        if (opcode_i == OP_ST) begin
          ctrl_o.wr_rdn = 1'b1;
        end else begin
          ctrl_o.busb_mdr_sel = 1'b1;
          ctrl_o.selop        = ALU_PASS;
          ctrl_o.bank_wr_en   = 1'b1;
          ctrl_o.busc_addr    = (opcode_i == OP_LD) ? R_ACC : R_PC;
          ctrl_o.enaf         = (opcode_i == OP_LD);
        end
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pdua_control_unit.sv
// PDUA hardwired control unit: state register and next-state logic;
// the control word comes from pdua_ctrl_decode.
// Build option: define PDUA_ILLEGAL_TRAP_EN to trap undefined opcodes
// into S_HALT and expose the illegal_op output.
module pdua_control_unit
  import pdua_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int OPC_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ready,
  input  logic [OPC_WIDTH-1:0]  opcode,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  wr_rdn,
  output logic                  enaf,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic                  bank_wr_en,
  output logic [ADDR_WIDTH-1:0] BusB_addr,
  output logic [ADDR_WIDTH-1:0] BusC_addr,
  output logic                  busb_mdr_sel,
  output logic                  sclr,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  halted
`ifdef PDUA_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  state_e     state_q, state_d;
  logic [4:0] op_w;
  ctrl_t      ctrl_w;

  assign op_w = 5'(opcode);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: state_d = S_FA;
      S_FA:   state_d = S_FM;
      S_FM:   if (mem_ready) state_d = S_FI;
      S_FI:   state_d = S_EX1;
      S_EX1: begin
        state_d = S_FA;
        if (op_w == OP_LD || op_w == OP_ST) begin
          state_d = S_EX2;
        end else if (is_jump(op_w) && jump_taken(op_w, C, N, P, Z)) begin
          state_d = S_EX2;
        end else if (op_w == OP_HALT) begin
          state_d = S_HALT;
        end
`ifdef PDUA_ILLEGAL_TRAP_EN
        else if (!is_defined(op_w)) begin
          state_d = S_HALT;
        end
`endif
      end
      // Store loads MDR unconditionally; reads wait for memory
      S_EX2:  if (op_w == OP_ST || mem_ready) state_d = S_EX3;
      // Store write waits for memory; other EX3 cycles are single
      S_EX3:  if (op_w != OP_ST || mem_ready) state_d = S_FA;
      S_HALT: state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  pdua_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (op_w),
    .mem_ready_i (mem_ready),
    .c_i         (C),
    .n_i         (N),
    .p_i         (P),
    .z_i         (Z),
    .ctrl_o      (ctrl_w)
  );

  assign wr_rdn       = ctrl_w.wr_rdn;
  assign enaf         = ctrl_w.enaf;
  assign selop        = ctrl_w.selop;
  assign shamt        = ctrl_w.shamt;
  assign bank_wr_en   = ctrl_w.bank_wr_en;
  assign BusB_addr    = ADDR_WIDTH'(ctrl_w.busb_addr);
  assign BusC_addr    = ADDR_WIDTH'(ctrl_w.busc_addr);
  assign busb_mdr_sel = ctrl_w.busb_mdr_sel;
  assign sclr         = ctrl_w.sclr;
  assign ir_en        = ctrl_w.ir_en;
  assign mar_en       = ctrl_w.mar_en;
  assign mdr_en       = ctrl_w.mdr_en;
  assign mdr_alu_n    = ctrl_w.mdr_alu_n;
  assign halted       = ctrl_w.halted;

`ifdef PDUA_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_now;

  assign illegal_now = (state_q == S_EX1) && !is_defined(op_w);

  // Remember the trap cause while halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             illegal_q <= 1'b0;
    else if (illegal_now) illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q | illegal_now;
`endif

endmodule

// File: tb/tb_pdua_control_unit.sv
// Directed testbench for pdua_control_unit.
module tb_pdua_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic [4:0] opcode;
  logic       C, N, P, Z;
  logic       wr_rdn, enaf, bank_wr_en, busb_mdr_sel, sclr;
  logic       ir_en, mar_en, mdr_en, mdr_alu_n, halted;
  logic [2:0] selop, BusB_addr, BusC_addr;
  logic [1:0] shamt;
`ifdef PDUA_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdua_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .C            (C),
    .N            (N),
    .P            (P),
    .Z            (Z),
    .wr_rdn       (wr_rdn),
    .enaf         (enaf),
    .selop        (selop),
    .shamt        (shamt),
    .bank_wr_en   (bank_wr_en),
    .BusB_addr    (BusB_addr),
    .BusC_addr    (BusC_addr),
    .busb_mdr_sel (busb_mdr_sel),
    .sclr         (sclr),
    .ir_en        (ir_en),
    .mar_en       (mar_en),
    .mdr_en       (mdr_en),
    .mdr_alu_n    (mdr_alu_n),
    .halted       (halted)
`ifdef PDUA_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  // Observed control word, field order:
  // wr_rdn enaf selop shamt bank_wr_en BusB BusC mdr_sel sclr ir mar mdr mdr_alu_n halted
  logic [20:0] obs;
  assign obs = {wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
                busb_mdr_sel, sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted};

  function automatic logic [20:0] cw(input logic wr, input logic en,
                                     input logic [2:0] sel, input logic [1:0] sh,
                                     input logic bwe, input logic [2:0] bb,
                                     input logic [2:0] bc, input logic msel,
                                     input logic clr, input logic ir,
                                     input logic mar, input logic mdr,
                                     input logic mal, input logic hlt);
    return {wr, en, sel, sh, bwe, bb, bc, msel, clr, ir, mar, mdr, mal, hlt};
  endfunction

  logic [20:0] w_init, w_fa, w_fm_wait, w_fm_rdy, w_fi, w_zero, w_halt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks FA -> FM (with 'waits' stall cycles) -> FI; ends in EX1
  task automatic fetch(input int waits, input string tag);
    if (obs !== w_fa) begin
      errors++; $display("FAIL %s fa: got %b want %b", tag, obs, w_fa);
    end
    checks++;
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < waits; i++) begin
      if (obs !== w_fm_wait) begin
        errors++; $display("FAIL %s fm_wait%0d: got %b want %b", tag, i, obs, w_fm_wait);
      end
      checks++;
      step();
    end
    mem_ready = 1'b1;
    #1;
    if (obs !== w_fm_rdy) begin
      errors++; $display("FAIL %s fm_rdy: got %b want %b", tag, obs, w_fm_rdy);
    end
    checks++;
    step();
    if (obs !== w_fi) begin
      errors++; $display("FAIL %s fi: got %b want %b", tag, obs, w_fi);
    end
    checks++;
    step();
  endtask

  task automatic expect_fa(input string tag);
    if (obs !== w_fa) begin
      errors++; $display("FAIL %s back_to_fa: got %b want %b", tag, obs, w_fa);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b0; opcode = 5'd0; {C, N, P, Z} = 4'b0000;
    step();
    step();
    if (obs !== w_init) begin
      errors++; $display("FAIL reset_hold: got %b want %b", obs, w_init);
    end
    checks++;
    rst = 1'b1;
    #1;
    if (obs !== w_init) begin
      errors++; $display("FAIL reset_release_init: got %b want %b", obs, w_init);
    end
    checks++;
    step();
    expect_fa("reset");
  endtask

  task automatic test_mov_acc_a();
    opcode = 5'b00001;
    fetch(0, "mov_acc_a");
    if (obs !== cw(0, 1, 3'b000, 2'b00, 1, 3'd3, 3'd7, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL mov_acc_a ex1: got %b", obs);
    end
    checks++;
    step();
    expect_fa("mov_acc_a");
  endtask

  task automatic test_fetch_wait();
    opcode = 5'b00000;
    fetch(3, "fetch_wait");
    if (obs !== w_zero) begin
      errors++; $display("FAIL fetch_wait nop_ex1: got %b want %b", obs, w_zero);
    end
    checks++;
    step();
    expect_fa("fetch_wait");
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops [6];
    logic [20:0] exps [6];
    ops[0] = 5'b00010; exps[0] = cw(0, 0, 3'b000, 2'b00, 1, 3'd7, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    ops[1] = 5'b00101; exps[1] = cw(0, 1, 3'b001, 2'b00, 1, 3'd3, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    ops[2] = 5'b00110; exps[2] = cw(0, 1, 3'b010, 2'b00, 1, 3'd3, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    ops[3] = 5'b00111; exps[3] = cw(0, 1, 3'b011, 2'b00, 1, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    ops[4] = 5'b01000; exps[4] = cw(0, 1, 3'b101, 2'b01, 1, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    ops[5] = 5'b01001; exps[5] = cw(0, 1, 3'b110, 2'b01, 1, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i];
      fetch(0, "alu");
      if (obs !== exps[i]) begin
        errors++; $display("FAIL alu_op%0d ex1: got %b want %b", ops[i], obs, exps[i]);
      end
      checks++;
      step();
    end
    expect_fa("alu");
  endtask

  task automatic test_load();
    opcode = 5'b00011;
    fetch(0, "load");
    if (obs !== cw(0, 0, 3'b000, 2'b00, 0, 3'd2, 3'd0, 0, 0, 0, 1, 0, 0, 0)) begin
      errors++; $display("FAIL load ex1: got %b", obs);
    end
    checks++;
    mem_ready = 1'b0;
    step();
    if (obs !== w_fm_wait) begin
      errors++; $display("FAIL load ex2_wait: got %b want %b", obs, w_fm_wait);
    end
    checks++;
    step();
    mem_ready = 1'b1;
    #1;
    if (obs !== w_fm_rdy) begin
      errors++; $display("FAIL load ex2_rdy: got %b want %b", obs, w_fm_rdy);
    end
    checks++;
    step();
    if (obs !== cw(0, 1, 3'b000, 2'b00, 1, 3'd0, 3'd7, 1, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL load ex3: got %b", obs);
    end
    checks++;
    step();
    expect_fa("load");
  endtask

  task automatic test_store();
    opcode = 5'b00100;
    fetch(0, "store");
    if (obs !== cw(0, 0, 3'b000, 2'b00, 0, 3'd2, 3'd0, 0, 0, 0, 1, 0, 0, 0)) begin
      errors++; $display("FAIL store ex1: got %b", obs);
    end
    checks++;
    mem_ready = 1'b0;
    step();
    if (obs !== cw(0, 0, 3'b000, 2'b00, 0, 3'd7, 3'd0, 0, 0, 0, 0, 1, 0, 0)) begin
      errors++; $display("FAIL store ex2: got %b", obs);
    end
    checks++;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      if (obs !== cw(1, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL store ex3_write%0d: got %b", i, obs);
      end
      checks++;
      step();
    end
    expect_fa("store");
  endtask

  task automatic test_jumps();
    // JZ not taken: PC <- PC+1 in one cycle
    opcode = 5'b01011; Z = 1'b0;
    fetch(0, "jz_nt");
    if (obs !== cw(0, 0, 3'b100, 2'b00, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL jz_nt ex1: got %b", obs);
    end
    checks++;
    step();
    expect_fa("jz_nt");
    // JZ taken; Z dropping after EX1 must not matter
    Z = 1'b1;
    fetch(0, "jz_t");
    if (obs !== w_fa) begin
      errors++; $display("FAIL jz_t ex1: got %b want %b", obs, w_fa);
    end
    checks++;
    step();
    Z = 1'b0;
    #1;
    if (obs !== w_fm_rdy) begin
      errors++; $display("FAIL jz_t ex2: got %b want %b", obs, w_fm_rdy);
    end
    checks++;
    step();
    if (obs !== cw(0, 0, 3'b000, 2'b00, 1, 3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL jz_t ex3: got %b", obs);
    end
    checks++;
    step();
    expect_fa("jz_t");
    // JC with C=0 not taken, JN with N=1 taken
    opcode = 5'b01101; {C, N, P, Z} = 4'b0111;
    fetch(0, "jc_nt");
    if (obs !== cw(0, 0, 3'b100, 2'b00, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL jc_nt ex1: got %b", obs);
    end
    checks++;
    step();
    opcode = 5'b01100; {C, N, P, Z} = 4'b0100;
    fetch(0, "jn_t");
    if (obs !== w_fa) begin
      errors++; $display("FAIL jn_t ex1: got %b want %b", obs, w_fa);
    end
    checks++;
    step(); step(); step();
    expect_fa("jn_t");
    {C, N, P, Z} = 4'b0000;
  endtask

  task automatic test_illegal();
    opcode = 5'b10101;
    fetch(0, "illegal");
`ifdef PDUA_ILLEGAL_TRAP_EN
    if (illegal_op !== 1'b1) begin
      errors++; $display("FAIL illegal ex1_flag: got %b want 1", illegal_op);
    end
    checks++;
    step();
    for (int i = 0; i < 3; i++) begin
      if (obs !== w_halt || illegal_op !== 1'b1) begin
        errors++; $display("FAIL illegal halted%0d: got %b/%b want %b/1", i, obs, illegal_op, w_halt);
      end
      checks++;
      step();
    end
    rst = 1'b0; step(); rst = 1'b1; step();
`else
    if (obs !== w_zero) begin
      errors++; $display("FAIL illegal ex1_nop: got %b want %b", obs, w_zero);
    end
    checks++;
    step();
    expect_fa("illegal");
`endif
  endtask

  task automatic test_reset_mid();
    // Abort MOV ACC,[DPTR] while waiting in EX2
    opcode = 5'b00011;
    fetch(0, "rst_mid_ld");
    mem_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    if (obs !== w_init) begin
      errors++; $display("FAIL rst_mid_ld abort: got %b want %b", obs, w_init);
    end
    checks++;
    step();
    rst = 1'b1;
    #1;
    if (obs !== w_init) begin
      errors++; $display("FAIL rst_mid_ld init: got %b want %b", obs, w_init);
    end
    checks++;
    step();
    expect_fa("rst_mid_ld");
    // Abort a store while the write strobe is up
    opcode = 5'b00100;
    fetch(0, "rst_mid_st");
    mem_ready = 1'b0;
    step(); step();
    if (wr_rdn !== 1'b1) begin
      errors++; $display("FAIL rst_mid_st write_up: got %b want 1", wr_rdn);
    end
    checks++;
    rst = 1'b0;
    #1;
    if (obs !== w_init) begin
      errors++; $display("FAIL rst_mid_st abort: got %b want %b", obs, w_init);
    end
    checks++;
    step();
    rst = 1'b1;
    step();
    expect_fa("rst_mid_st");
  endtask

  task automatic test_halt();
    opcode = 5'b11111;
    fetch(0, "halt");
    if (obs !== w_zero) begin
      errors++; $display("FAIL halt ex1: got %b want %b", obs, w_zero);
    end
    checks++;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      opcode = 5'b00001;
      #1;
      if (obs !== w_halt) begin
        errors++; $display("FAIL halt stay%0d: got %b want %b", i, obs, w_halt);
      end
      checks++;
      step();
    end
    rst = 1'b0; step(); rst = 1'b1; step();
    expect_fa("halt_exit");
  endtask

  initial begin
    w_init    = cw(0, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 0);
    w_fa      = cw(0, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    w_fm_wait = cw(0, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 0);
    w_fm_rdy  = cw(0, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1, 0);
    w_fi      = cw(0, 0, 3'b100, 2'b00, 1, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0);
    w_zero    = '0;
    w_halt    = cw(0, 0, 3'b000, 2'b00, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1);

    test_reset();
    test_mov_acc_a();
    test_fetch_wait();
    test_alu_ops();
    test_load();
    test_store();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
